// File: rtl/piso_shift_ctrl.sv
// Parallel-in/serial-out shifter with load handshake, bit counter and done pulse.
// Define PISO_PARITY_EN to append an even-parity trailer bit after each frame.
module piso_shift_ctrl #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             clk_inh,
  input  logic             ser_in,
  output logic             qh,
  output logic             qh_inv,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] regs_q, regs_d;
  logic [CW-1:0]    count_q, count_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] shifted;
  logic             head;

  // One-step shift of the word with ser_in entering the vacated end.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (MSB_FIRST) begin : g_msb
        if (gi == 0) begin : g_end
          assign shifted[gi] = ser_in;
        end else begin : g_mid
          assign shifted[gi] = regs_q[gi-1];
        end
      end else begin : g_lsb
        if (gi == WIDTH - 1) begin : g_end
          assign shifted[gi] = ser_in;
        end else begin : g_mid
          assign shifted[gi] = regs_q[gi+1];
        end
      end
    end
  endgenerate

  assign head = MSB_FIRST ? regs_q[WIDTH-1] : regs_q[0];

`ifdef PISO_PARITY_EN
  logic par_q, par_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  always_comb begin
    par_d = par_q;
    if (state_q == ST_IDLE && load_valid) begin
      par_d = ^in;
    end
  end

  assign qh = (state_q == ST_PAR) ? par_q : head;
`else
  assign qh = head;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      regs_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    count_d = count_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          regs_d  = in;
          count_d = CW'(WIDTH);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!clk_inh) begin
          regs_d = shifted;
          if (count_q != '0) begin
            count_d = count_q - CW'(1);
          end
          // Last data bit leaves on this advance.
          if (count_q <= CW'(1)) begin
`ifdef PISO_PARITY_EN
            state_d = ST_PAR;
`else
            state_d = ST_IDLE;
            done_d  = 1'b1;
`endif
          end
        end
      end
`ifdef PISO_PARITY_EN
      ST_PAR: begin
        if (!clk_inh) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign qh_inv     = ~qh;
  assign load_ready = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;

endmodule
